periph_reg_demux: RTL and testbench



---
 rtl/periph_reg_demux_pkg.sv | 47 ++++
 rtl/periph_reg_addr_decode.sv | 29 ++
 rtl/periph_reg_demux.sv | 144 ++++++++++++++
 tb/tb_periph_reg_demux.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_reg_demux_pkg.sv
// Shared definitions for the peripheral register-bus demultiplexer:
// reg-bus request/response types, address-map rule type, the default
// register map and the demux FSM state encoding.
package periph_reg_demux_pkg;

   localparam int unsigned NUM_SLAVES     = 3;
   localparam int unsigned TIMEOUT_CYCLES = 256;

   // Register-bus request: 64-bit address, 32-bit data, 4-bit strobe.
   typedef struct packed {
      logic [63:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   // Register-bus response.
   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   // One address-map rule; end_addr is exclusive.
   typedef struct packed {
      logic [31:0] idx;
      logic [63:0] start_addr;
      logic [63:0] end_addr;
   } rule_t;

   // Peripheral register map: SOC_CTRL, FAST_INTR_CTRL, UART.
   // Element [0] is the rightmost term of the concatenation.
   localparam rule_t [NUM_SLAVES-1:0] REG_MAP = {
      rule_t'{idx: 32'd2, start_addr: 64'h1000_2000_0000_0000, end_addr: 64'h1000_3000_0000_0000},
      rule_t'{idx: 32'd1, start_addr: 64'h1000_1000_0000_0000, end_addr: 64'h1000_2000_0000_0000},
      rule_t'{idx: 32'd0, start_addr: 64'h1000_0000_0000_0000, end_addr: 64'h1000_1000_0000_0000}
   };

   // Demux transaction sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

endpackage

// File: rtl/periph_reg_addr_decode.sv
// Combinational address-range decoder for reg-bus demultiplexers.
// A rule hits when start_addr <= addr < end_addr; when several rules
// overlap, the rule at the lowest array position wins.
module periph_reg_addr_decode
   import periph_reg_demux_pkg::*;
#(
   parameter int unsigned          NumRules = NUM_SLAVES,
   parameter int unsigned          IdxW     = (NumRules > 1) ? $clog2(NumRules) : 1,
   parameter rule_t [NumRules-1:0] Map      = REG_MAP
) (
   input  logic [63:0]     addr,
   output logic            hit,
   output logic [IdxW-1:0] idx
);

   // Scan from the highest rule down so the lowest matching rule is the last writer.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      hit = 1'b0;
      idx = '0;
      for (int i = int'(NumRules) - 1; i >= 0; i--) begin
         if ((addr >= Map[i].start_addr) && (addr < Map[i].end_addr)) begin
            hit = 1'b1;
            idx = Map[i].idx[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/periph_reg_demux.sv
// Register-bus demultiplexer and transaction sequencer. Accepts one
// upstream request at a time, forwards it to the single slave whose
// address range it hits, answers unmapped addresses with an error, and
// aborts a forwarded transaction if the slave stays silent for
// TimeoutCycles cycles (TimeoutCycles must be at least 2).
module periph_reg_demux
   import periph_reg_demux_pkg::*;
#(
   parameter int unsigned           NumSlaves     = NUM_SLAVES,
   parameter int unsigned           TimeoutCycles = TIMEOUT_CYCLES,
   parameter rule_t [NumSlaves-1:0] RegMap        = REG_MAP
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  reg_req_t                 slv_req_i,
   output reg_rsp_t                 slv_rsp_o,
   output reg_req_t [NumSlaves-1:0] mst_req_o,
   input  reg_rsp_t [NumSlaves-1:0] mst_rsp_i,
   output logic                     timeout_o,
   output logic [15:0]              err_cnt_o
);

   localparam int unsigned    IdxW    = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
   localparam int unsigned    CntW    = $clog2(TimeoutCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   state_e          state_q, state_d;
   reg_req_t        req_q;       // latched copy of the accepted request
   logic [IdxW-1:0] sel_q;       // slave selected by the decode
   logic [CntW-1:0] cnt_q;       // cycles the selected slave has been waited on
   logic            timeout_q;
   logic [15:0]     err_cnt_q;

   logic            dec_hit;
   logic [IdxW-1:0] dec_idx;
   reg_rsp_t        sel_rsp;
   logic            err_inc;
   logic            timeout_hit;

   periph_reg_addr_decode #(
      .NumRules (NumSlaves),
      .IdxW     (IdxW),
      .Map      (RegMap)
   ) u_decode (
      .addr (slv_req_i.addr),
      .hit  (dec_hit),
      .idx  (dec_idx)
   );

   // Pick the response of the currently selected slave.
   always_comb begin
      sel_rsp = '0;
      for (int i = 0; i < int'(NumSlaves); i++) begin
         if (sel_q == IdxW'(i)) sel_rsp = mst_rsp_i[i];
      end
   end

   // Next-state logic plus decode-error and timeout events.
   always_comb begin
      state_d     = state_q;
      err_inc     = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (slv_req_i.valid) begin
               if (dec_hit) begin
                  state_d = ST_FWD;
               end else begin
                  state_d = ST_ERR;
                  err_inc = 1'b1;
               end
            end
         end
         ST_FWD: begin
            // A response arriving on the last allowed cycle still wins.
            if (sel_rsp.ready) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CntLast) begin
               state_d     = ST_ERR;
               err_inc     = 1'b1;
               timeout_hit = 1'b1;
            end
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, request latch, wait counter, timeout pulse and error counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q   <= state_d;
         timeout_q <= timeout_hit;
         if ((state_q == ST_IDLE) && slv_req_i.valid) begin
            req_q <= slv_req_i;
            sel_q <= dec_idx;
            cnt_q <= '0;
         end else if ((state_q == ST_FWD) && !sel_rsp.ready) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   // Drive slave requests and the upstream response from the current state.
   always_comb begin
      mst_req_o = '0;
      slv_rsp_o = '0;
      case (state_q)
         ST_FWD: begin
            for (int i = 0; i < int'(NumSlaves); i++) begin
               if (sel_q == IdxW'(i)) begin
                  mst_req_o[i]       = req_q;
                  mst_req_o[i].valid = 1'b1;
               end
            end
            if (sel_rsp.ready) begin
               slv_rsp_o.rdata = sel_rsp.rdata;
               slv_rsp_o.error = sel_rsp.error;
               slv_rsp_o.ready = 1'b1;
            end
         end
         ST_ERR: begin
            slv_rsp_o.error = 1'b1;
            slv_rsp_o.ready = 1'b1;
         end
         default: ;
      endcase
   end

   assign timeout_o = timeout_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_periph_reg_demux.sv
// Bench for periph_reg_demux: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the demux.
module tb_periph_reg_demux;
   import periph_reg_demux_pkg::*;

   localparam int          NS   = 3;
   localparam int          T    = 8;
   localparam logic [63:0] BASE = 64'h1000_0000_0000_0000;
   localparam logic [63:0] SIZE = 64'h0000_1000_0000_0000;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   reg_req_t          slv_req;
   reg_rsp_t          slv_rsp;
   reg_req_t [NS-1:0] mst_req;
   reg_rsp_t [NS-1:0] mst_rsp;
   logic              timeout;
   logic [15:0]       err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Slave stub configuration: wait cycles before ready, read data, error flag,
   // and a random ready level shown while the stub is not being addressed.
   int          stub_wait  [NS];
   logic [31:0] stub_rdata [NS];
   logic        stub_err   [NS];
   logic        stub_noise [NS];
   logic [7:0]  stub_age   [NS];

   always #5 clk = ~clk;

   periph_reg_demux #(
      .NumSlaves     (NS),
      .TimeoutCycles (T),
      .RegMap        (REG_MAP)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .slv_req_i (slv_req),
      .slv_rsp_o (slv_rsp),
      .mst_req_o (mst_req),
      .mst_rsp_i (mst_rsp),
      .timeout_o (timeout),
      .err_cnt_o (err_cnt)
   );

   // Stub: count consecutive cycles each slave has seen valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NS; i++) stub_age[i] <= '0;
      end else begin
         for (int i = 0; i < NS; i++) begin
            if (mst_req[i].valid) stub_age[i] <= stub_age[i] + 8'd1;
            else                  stub_age[i] <= '0;
         end
      end
   end

   // Stub: answer after stub_wait valid cycles.
   always_comb begin
      mst_rsp = '0;
      for (int i = 0; i < NS; i++) begin
         mst_rsp[i].rdata = stub_rdata[i];
         mst_rsp[i].error = stub_err[i];
         if (mst_req[i].valid) mst_rsp[i].ready = (int'(stub_age[i]) == stub_wait[i]);
         else                  mst_rsp[i].ready = stub_noise[i];
      end
   end

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Region index of an address from the map's arithmetic layout, -1 if unmapped.
   function automatic int model_decode(input logic [63:0] a);
      logic [63:0] q;
      if (a < BASE) return -1;
      q = (a - BASE) / SIZE;
      if (q < 64'(NS)) return int'(q);
      return -1;
   endfunction

   function automatic logic [NS-1:0] valid_vec(input reg_req_t [NS-1:0] r);
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) v[i] = r[i].valid;
      return v;
   endfunction

   function automatic logic [63:0] rand_addr();
      int          s = int'($urandom_range(0, NS - 1));
      logic [63:0] r = {$urandom, $urandom};
      case ($urandom_range(0, 6))
         0, 1:    return BASE + 64'(s) * SIZE + (r % SIZE);
         2:       return BASE + 64'(s) * SIZE;
         3:       return BASE + 64'(s + 1) * SIZE - 64'd1;
         4:       return BASE + 64'(NS) * SIZE;
         5:       return BASE - 64'd1;
         default: return r;
      endcase
   endfunction

   // Transaction-level reference: every cycle, compare outputs with what the
   // in-flight transaction (if any) must show at its current age.
   initial begin : model_compare
      bit                busy   = 1'b0;
      int                age    = 0;
      int                tgt    = -1;
      int                t_wait = 0;
      reg_req_t          t_req  = '0;
      logic [31:0]       t_rdata = '0;
      logic              t_err  = 1'b0;
      logic [15:0]       exp_err = '0;
      reg_req_t [NS-1:0] e_req;
      reg_rsp_t          e_rsp;
      logic              e_to;
      bit                last;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("reset_mst_req", 320'(mst_req), 320'(0));
            check("reset_slv_rsp", 320'(slv_rsp), 320'(0));
            check("reset_timeout", 320'(timeout), 320'(0));
            check("reset_err_cnt", 320'(err_cnt), 320'(0));
            busy    = 1'b0;
            exp_err = '0;
         end else begin
            e_req = '0;
            e_rsp = '0;
            e_to  = 1'b0;
            if (busy) begin
               if (tgt < 0) begin
                  e_rsp = '{rdata: 32'd0, error: 1'b1, ready: 1'b1};
               end else if (t_wait < T) begin
                  e_req[tgt] = t_req;
                  if (age == t_wait + 1) e_rsp = '{rdata: t_rdata, error: t_err, ready: 1'b1};
               end else if (age <= T) begin
                  e_req[tgt] = t_req;
               end else begin
                  e_rsp = '{rdata: 32'd0, error: 1'b1, ready: 1'b1};
                  e_to  = 1'b1;
               end
            end
            check("mst_req", 320'(mst_req), 320'(e_req));
            check("slv_rsp", 320'(slv_rsp), 320'(e_rsp));
            check("timeout", 320'(timeout), 320'(e_to));
            check("err_cnt", 320'(err_cnt), 320'(exp_err));
            if (busy) begin
               if (tgt < 0)           last = (age == 1);
               else if (t_wait < T)   last = (age == t_wait + 1);
               else                   last = (age == T + 1);
               if (last) begin
                  busy = 1'b0;
               end else begin
                  age++;
                  if ((tgt >= 0) && (t_wait >= T) && (age == T + 1) && (exp_err != 16'hFFFF))
                     exp_err++;
               end
            end else if (slv_req.valid) begin
               busy  = 1'b1;
               age   = 1;
               t_req = slv_req;
               tgt   = model_decode(slv_req.addr);
               if (tgt >= 0) begin
                  t_wait  = stub_wait[tgt];
                  t_rdata = stub_rdata[tgt];
                  t_err   = stub_err[tgt];
               end else if (exp_err != 16'hFFFF) begin
                  exp_err++;
               end
            end
         end
      end
   end

   task automatic set_stub(input int i, input int w, input logic [31:0] rd, input logic er);
      stub_wait[i]  = w;
      stub_rdata[i] = rd;
      stub_err[i]   = er;
   endtask

   task automatic drive(input logic [63:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] ws);
      slv_req = '{addr: a, write: wr, wdata: wd, wstrb: ws, valid: 1'b1};
   endtask

   // Follow one transaction from the cycle its valid is first presented until ready.
   task automatic wait_ready(input bit scramble, output int lat, output int vcnt,
                             output reg_rsp_t rsp, output logic to, output logic [15:0] ec,
                             output reg_req_t [NS-1:0] rq);
      bit got = 1'b0;
      lat = 0; vcnt = 0; rsp = '0; to = 1'b0; ec = '0; rq = '0;
      while (!got && (lat <= 40)) begin
         @(negedge clk);
         if (|valid_vec(mst_req)) vcnt++;
         if (slv_rsp.ready) begin
            got = 1'b1;
            rsp = slv_rsp;
            to  = timeout;
            ec  = err_cnt;
            rq  = mst_req;
         end else begin
            // After acceptance the upstream fields must no longer matter.
            if (scramble && (lat >= 1)) begin
               #1;
               slv_req.addr  = {$urandom, $urandom};
               slv_req.wdata = $urandom;
               slv_req.wstrb = 4'($urandom_range(0, 15));
               slv_req.write = 1'($urandom_range(0, 1));
            end
            lat++;
         end
      end
      check("handshake_seen", 320'(got), 320'(1'b1));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      int                lat, vcnt;
      reg_rsp_t          rsp;
      logic              to;
      logic [15:0]       ec;
      reg_req_t [NS-1:0] rq;
      int                gap;

      slv_req = '0;
      for (int i = 0; i < NS; i++) begin
         set_stub(i, 0, 32'd0, 1'b0);
         stub_noise[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Read FAST_INTR_CTRL, zero wait.
      @(posedge clk); #1;
      set_stub(1, 0, 32'hDEAD_BEEF, 1'b0);
      drive(64'h1000_1000_0000_0004, 1'b0, 32'd0, 4'd0);
      wait_ready(1'b0, lat, vcnt, rsp, to, ec, rq);
      check("rd_fic_latency", 320'(lat), 320'(1));
      check("rd_fic_rsp", 320'(rsp), 320'({32'hDEAD_BEEF, 1'b0, 1'b1}));
      check("rd_fic_valid_vec", 320'(valid_vec(rq)), 320'(3'b010));
      check("rd_fic_valid_cycles", 320'(vcnt), 320'(1));
      @(posedge clk); #1 slv_req.valid = 1'b0;
      @(negedge clk);
      check("rd_fic_valid_dropped", 320'(valid_vec(mst_req)), 320'(0));

      // Write UART at the top of its range, 3 wait cycles.
      @(posedge clk); #1;
      set_stub(2, 3, 32'h0BAD_F00D, 1'b0);
      drive(64'h1000_2FFF_FFFF_FFFC, 1'b1, 32'h0000_0055, 4'hF);
      wait_ready(1'b1, lat, vcnt, rsp, to, ec, rq);
      check("wr_uart_latency", 320'(lat), 320'(4));
      check("wr_uart_addr", 320'(rq[2].addr), 320'(64'h1000_2FFF_FFFF_FFFC));
      check("wr_uart_fields", 320'({rq[2].write, rq[2].wdata, rq[2].wstrb}), 320'({1'b1, 32'h55, 4'hF}));
      check("wr_uart_valid_vec", 320'(valid_vec(rq)), 320'(3'b100));
      check("wr_uart_valid_cycles", 320'(vcnt), 320'(4));

      // UART end address is exclusive: unmapped.
      @(posedge clk); #1;
      drive(64'h1000_3000_0000_0000, 1'b0, 32'd0, 4'd0);
      wait_ready(1'b0, lat, vcnt, rsp, to, ec, rq);
      check("unmapped_latency", 320'(lat), 320'(1));
      check("unmapped_rsp", 320'(rsp), 320'({32'd0, 1'b1, 1'b1}));
      check("unmapped_no_valid", 320'(vcnt), 320'(0));
      check("unmapped_err_cnt", 320'(ec), 320'(1));

      // SOC_CTRL never answers: abort after T forwarded cycles.
      @(posedge clk); #1;
      set_stub(0, 255, 32'h1111_1111, 1'b0);
      drive(64'h1000_0000_0000_0100, 1'b0, 32'd0, 4'd0);
      wait_ready(1'b0, lat, vcnt, rsp, to, ec, rq);
      check("timeout_latency", 320'(lat), 320'(T + 1));
      check("timeout_valid_cycles", 320'(vcnt), 320'(T));
      check("timeout_pulse", 320'(to), 320'(1'b1));
      check("timeout_rsp", 320'(rsp), 320'({32'd0, 1'b1, 1'b1}));
      check("timeout_err_cnt", 320'(ec), 320'(2));

      // Ready on the last allowed cycle: normal response, no abort.
      @(posedge clk); #1;
      set_stub(0, T - 1, 32'hCAFE_0007, 1'b0);
      drive(64'h1000_0000_0000_0200, 1'b0, 32'd0, 4'd0);
      wait_ready(1'b0, lat, vcnt, rsp, to, ec, rq);
      check("late_ready_latency", 320'(lat), 320'(T));
      check("late_ready_rsp", 320'(rsp), 320'({32'hCAFE_0007, 1'b0, 1'b1}));
      check("late_ready_no_timeout", 320'(to), 320'(1'b0));
      check("late_ready_err_cnt", 320'(ec), 320'(2));

      // Reset while forwarding.
      @(posedge clk); #1;
      set_stub(0, 255, 32'd0, 1'b0);
      drive(64'h1000_0000_0000_0010, 1'b1, 32'h1234_5678, 4'h3);
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_valid", 320'(mst_req[0].valid), 320'(1'b1));
      @(posedge clk); #3;
      rst_n = 1'b0;
      slv_req.valid = 1'b0;
      #1;
      check("rst_async_valid", 320'(valid_vec(mst_req)), 320'(0));
      check("rst_async_err_cnt", 320'(err_cnt), 320'(0));
      check("rst_async_rsp", 320'(slv_rsp), 320'(0));
      @(posedge clk); #3 rst_n = 1'b1;

      // First access after reset behaves as the very first one.
      @(posedge clk); #1;
      set_stub(1, 0, 32'hDEAD_BEEF, 1'b0);
      drive(64'h1000_1000_0000_0004, 1'b0, 32'd0, 4'd0);
      wait_ready(1'b0, lat, vcnt, rsp, to, ec, rq);
      check("post_rst_latency", 320'(lat), 320'(1));
      check("post_rst_rsp", 320'(rsp), 320'({32'hDEAD_BEEF, 1'b0, 1'b1}));
      check("post_rst_valid_vec", 320'(valid_vec(rq)), 320'(3'b010));

      // Randomized traffic, checked every cycle by the model.
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NS; i++) begin
            stub_wait[i]  = int'($urandom_range(0, 10));
            stub_rdata[i] = $urandom;
            stub_err[i]   = 1'($urandom_range(0, 1));
            stub_noise[i] = 1'($urandom_range(0, 1));
         end
         gap = int'($urandom_range(0, 2));
         if (gap > 0) begin
            slv_req       = '0;
            slv_req.addr  = {$urandom, $urandom};
            slv_req.wdata = $urandom;
            repeat (gap) begin
               @(posedge clk); #1;
            end
         end
         drive(rand_addr(), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
         wait_ready(1'b1, lat, vcnt, rsp, to, ec, rq);
      end

      @(posedge clk); #1 slv_req = '0;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
